cla_response_checker: RTL and testbench
=======================================

Name: cla_response_checker

Overview:
- Self-checking response end for the 4-bit carry look-ahead adder path.
- Accepts operand/result tuples (a, b, cin, sum, cout) over a valid/ready handshake and recomputes the expected {cout,sum} behaviourally.
- Counts passes and failures and captures the first failing tuple.
- Sits downstream of the adder in self-test and bring-up builds, replacing manual waveform inspection.

Parameters:
- WIDTH, 4, operand/sum width in bits.
- CNT_W, 16, width of the pass and fail counters.
- HALT_ON_ERR, 0, when 1 the checker stops accepting tuples after the first mismatch until clear.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of counters, sticky flag, capture registers and pipeline.
- in_valid  input  1  tuple present on a/b/cin/sum/cout.
- in_ready  output  1  checker can accept a tuple this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- sum  input  WIDTH  DUT sum under check.
- cout  input  1  DUT carry out under check.
- chk_valid  output  1  one-cycle pulse: a compare result is presented.
- chk_pass  output  1  result of that compare, qualified by chk_valid.
- pass_cnt  output  CNT_W  number of passing compares, saturating.
- fail_cnt  output  CNT_W  number of failing compares, saturating.
- err_flag  output  1  sticky: at least one mismatch since reset/clear.
- err_a, err_b  output  WIDTH  operands of the first failing tuple.
- err_cin  output  1  cin of the first failing tuple.
- err_sum  output  WIDTH  DUT sum of the first failing tuple.
- err_cout  output  1  DUT cout of the first failing tuple.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0 except in_ready; state=RUN; stage-1 valid=0. in_ready=1 once rst_n deasserts.
- Accept: a tuple is accepted on a rising edge where in_valid && in_ready. in_valid without in_ready is ignored and the tuple is not held.
- Stage 1 (accept edge E0): register the tuple and set s1_valid.
- Stage 2 (edge E1 = E0+1):
  - expected = a + b + cin, computed at WIDTH+1 bits; expected[WIDTH] is compared with cout, expected[WIDTH-1:0] with sum.
  - chk_valid=1 for exactly one cycle; chk_pass = match.
  - Counters update on the same edge. Latency from accept to result: 2 edges.
- Throughput: one tuple per cycle. Back-to-back accepts produce back-to-back chk_valid pulses.
- Counters saturate at 2^CNT_W-1 and never wrap.
- First-failure capture: on a mismatch while err_flag=0, latch err_* from the stage-1 tuple and set err_flag. Later mismatches only increment fail_cnt.
- FSM, two states:
  - RUN: in_ready = !clear.
  - HALT: in_ready = 0.
  - RUN->HALT on a mismatch result when HALT_ON_ERR=1.
  - HALT->RUN on clear.
  - HALT_ON_ERR=0: always RUN.
- Drain in HALT: a tuple already in stage 1 when HALT is entered still completes next edge and is counted. It never overwrites the err_* capture.
- clear (synchronous, one cycle):
  - zero pass_cnt, fail_cnt, err_flag, err_*, chk_valid.
  - flush s1_valid; state=RUN.
  - Has priority over a simultaneous compare result and a simultaneous accept; both are discarded.
  - in_ready is 0 during the clear cycle.
- Reset mid-operation: in-flight tuple lost; no chk_valid pulse after reset release.

Test Plan:
- Reset, then apply a=0,b=0,cin=0,sum=0,cout=0 -> chk_valid pulse 2 edges later; chk_pass=1; pass_cnt=1; err_flag=0.
- Back-to-back correct tuples on consecutive cycles: (2,6,1->9,0), (15,13,0->12,1), (10,5,0->15,0), (3,12,1->0,1) -> four consecutive chk_valid pulses, all pass; pass_cnt=4; fail_cnt=0.
- Faulty tuples (3,12,1, sum=15, cout=0) then (2,6,1, sum=8, cout=0), HALT_ON_ERR=0 -> fail_cnt=2; err_flag=1; err_a=3, err_b=12, err_cin=1, err_sum=15, err_cout=0 (first failure kept); in_ready stays 1.
- HALT_ON_ERR=1: faulty tuple followed immediately by a correct tuple (10,5,0->15,0) -> in_ready=0 after the failure edge; the trailing tuple drains with pass_cnt=1 and fail_cnt=1; further in_valid ignored. Pulse clear -> counters 0, err_flag=0, in_ready=1 next cycle.
- clear asserted on the same edge as a pending compare and a new accept -> no chk_valid; counters remain 0; the new tuple is not counted.
- CNT_W=2: five correct tuples -> pass_cnt saturates at 3. Assert rst_n low mid-stream -> all outputs 0 asynchronously; no result pulse after release.

Source files
------------

// File: rtl/cla_response_checker.sv
// Response checker for the carry look-ahead adder path. It recomputes {cout,sum}
// from (a,b,cin), counts passes and failures, and captures the first failing tuple.
module cla_response_checker #(
   parameter int WIDTH       = 4,
   parameter int CNT_W       = 16,
   parameter bit HALT_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_flag,
   output logic [WIDTH-1:0] err_a,
   output logic [WIDTH-1:0] err_b,
   output logic             err_cin,
   output logic [WIDTH-1:0] err_sum,
   output logic             err_cout
);

   typedef enum logic {RUN, HALT} state_t;

   state_t           state, state_nx;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a, s1_b, s1_sum;
   logic             s1_cin, s1_cout;
   logic [WIDTH:0]   expected;
   logic             match;
   logic             fail_now;
   logic             accept;

   assign in_ready = (state == RUN) && !clear;
   assign accept   = in_valid && in_ready;

   always_comb begin
      expected = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
      match    = (expected == {s1_cout, s1_sum});
      fail_now = s1_valid && !match;
   end

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (fail_now && HALT_ON_ERR) state_nx = HALT;
         HALT:    state_nx = HALT;
         default: state_nx = RUN;
      endcase
      if (clear) state_nx = RUN;
   end

   // NOTE: the stage-1 payload has no reset; it is only ever read while s1_valid is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a    <= a;
         s1_b    <= b;
         s1_cin  <= cin;
         s1_sum  <= sum;
         s1_cout <= cout;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         s1_valid  <= 1'b0;
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err_flag  <= 1'b0;
         err_a     <= '0;
         err_b     <= '0;
         err_cin   <= 1'b0;
         err_sum   <= '0;
         err_cout  <= 1'b0;
      end else if (clear) begin
         // clear wins over a compare completing and any accept in the same cycle
         state     <= RUN;
         s1_valid  <= 1'b0;
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err_flag  <= 1'b0;
         err_a     <= '0;
         err_b     <= '0;
         err_cin   <= 1'b0;
         err_sum   <= '0;
         err_cout  <= 1'b0;
      end else begin
         state     <= state_nx;
         s1_valid  <= accept;
         chk_valid <= s1_valid;
         chk_pass  <= s1_valid && match;
         if (s1_valid && match) begin
            if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + CNT_W'(1);
         end
         if (fail_now) begin
            if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
            if (!err_flag) begin
               err_flag <= 1'b1;
               err_a    <= s1_a;
               err_b    <= s1_b;
               err_cin  <= s1_cin;
               err_sum  <= s1_sum;
               err_cout <= s1_cout;
            end
         end
      end
   end

endmodule

// File: tb/tb_cla_response_checker.sv
// Scoreboard bench: two checker instances (free-running 16-bit counters, and halting
// with 2-bit counters) share one tuple bus and are compared against a behavioural model.
module tb_cla_response_checker;

   typedef struct {
      logic [3:0] a, b, s;
      logic       ci, co;
   } tuple_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a = '0, b = '0, sum = '0;
   logic       cin = 1'b0, cout = 1'b0;
   logic       vld [2] = '{1'b0, 1'b0};
   logic       clr [2] = '{1'b0, 1'b0};

   logic        rdy0, cv0, cp0, ef0, eci0, eco0;
   logic [15:0] pc0, fc0;
   logic [3:0]  ea0, eb0, es0;
   logic        rdy1, cv1, cp1, ef1, eci1, eco1;
   logic [1:0]  pc1, fc1;
   logic [3:0]  ea1, eb1, es1;

   always #5 clk = ~clk;

   cla_response_checker #(.WIDTH(4), .CNT_W(16), .HALT_ON_ERR(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(vld[0]), .in_ready(rdy0),
      .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
      .chk_valid(cv0), .chk_pass(cp0), .pass_cnt(pc0), .fail_cnt(fc0), .err_flag(ef0),
      .err_a(ea0), .err_b(eb0), .err_cin(eci0), .err_sum(es0), .err_cout(eco0));

   cla_response_checker #(.WIDTH(4), .CNT_W(2), .HALT_ON_ERR(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(vld[1]), .in_ready(rdy1),
      .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
      .chk_valid(cv1), .chk_pass(cp1), .pass_cnt(pc1), .fail_cnt(fc1), .err_flag(ef1),
      .err_a(ea1), .err_b(eb1), .err_cin(eci1), .err_sum(es1), .err_cout(eco1));

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: per-instance counts, halt flag, first-failure capture, in-flight tuple.
   bit     halt_cfg [2] = '{1'b0, 1'b1};
   int     cnt_max  [2] = '{65535, 3};
   int     m_pass   [2] = '{0, 0};
   int     m_fail   [2] = '{0, 0};
   bit     m_err    [2] = '{1'b0, 1'b0};
   bit     m_halt   [2] = '{1'b0, 1'b0};
   bit     pend_v   [2] = '{1'b0, 1'b0};
   tuple_t pend     [2];
   tuple_t m_cap    [2];
   bit     rq0 [$];
   bit     rq1 [$];

   function automatic bit tuple_ok(input tuple_t t);
      return (int'(t.a) + int'(t.b) + int'(t.ci)) == (int'(t.co) * 16 + int'(t.s));
   endfunction

   task automatic model_reset(input int i);
      m_pass[i] = 0;
      m_fail[i] = 0;
      m_err[i]  = 1'b0;
      m_halt[i] = 1'b0;
      pend_v[i] = 1'b0;
      m_cap[i]  = '{a: 4'd0, b: 4'd0, s: 4'd0, ci: 1'b0, co: 1'b0};
      if (i == 0) rq0.delete(); else rq1.delete();
   endtask

   task automatic model_step(input int i);
      bit halted_before;
      bit p;
      halted_before = m_halt[i];
      if (pend_v[i]) begin
         p = tuple_ok(pend[i]);
         if (i == 0) rq0.push_back(p); else rq1.push_back(p);
         if (p) begin
            if (m_pass[i] < cnt_max[i]) m_pass[i]++;
         end else begin
            if (m_fail[i] < cnt_max[i]) m_fail[i]++;
            if (!m_err[i]) begin
               m_err[i] = 1'b1;
               m_cap[i] = pend[i];
            end
            if (halt_cfg[i]) m_halt[i] = 1'b1;
         end
      end
      pend_v[i] = vld[i] && !halted_before;
      pend[i]   = '{a: a, b: b, s: sum, ci: cin, co: cout};
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n || clr[i]) model_reset(i);
            else model_step(i);
         end
      end
   end

   function automatic logic [63:0] expect_vec(input int i, input bit cv, input bit cp);
      return {14'd0, !m_halt[i] && !clr[i], cv, cp, m_err[i], m_cap[i].a, m_cap[i].b,
              m_cap[i].ci, m_cap[i].s, m_cap[i].co, 16'(m_pass[i]), 16'(m_fail[i])};
   endfunction

   // Monitor: every negedge pops a result whenever one is due or the DUT presents one.
   initial begin
      bit cv, cp;
      forever begin
         @(negedge clk);
         cv = (rq0.size() != 0);
         cp = cv ? rq0.pop_front() : 1'b0;
         check("inst0_status",
               {14'd0, rdy0, cv0, cv0 & cp0, ef0, ea0, eb0, eci0, es0, eco0, pc0, fc0},
               expect_vec(0, cv, cp));
         cv = (rq1.size() != 0);
         cp = cv ? rq1.pop_front() : 1'b0;
         check("inst1_status",
               {14'd0, rdy1, cv1, cv1 & cp1, ef1, ea1, eb1, eci1, es1, eco1, 14'd0, pc1, 14'd0, fc1},
               expect_vec(1, cv, cp));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [3:0] ta, input logic [3:0] tb,
                      input logic tci, input logic [3:0] ts, input logic tco);
      vld[i]     = 1'b1;
      vld[1 - i] = 1'b0;
      a = ta; b = tb; cin = tci; sum = ts; cout = tco;
      cyc();
   endtask

   task automatic idle(input int n);
      vld[0] = 1'b0; vld[1] = 1'b0;
      clr[0] = 1'b0; clr[1] = 1'b0;
      repeat (n) cyc();
   endtask

   initial begin
      logic [4:0] t;
      repeat (2) cyc();
      rst_n = 1'b1;
      idle(1);

      // single all-zero tuple
      put(0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
      idle(3);

      // back-to-back correct tuples
      put(0, 4'd2, 4'd6, 1'b1, 4'd9, 1'b0);
      put(0, 4'd15, 4'd13, 1'b0, 4'd12, 1'b1);
      put(0, 4'd10, 4'd5, 1'b0, 4'd15, 1'b0);
      put(0, 4'd3, 4'd12, 1'b1, 4'd0, 1'b1);
      idle(3);

      // two faulty tuples, first one must stay captured
      put(0, 4'd3, 4'd12, 1'b1, 4'd15, 1'b0);
      put(0, 4'd2, 4'd6, 1'b1, 4'd8, 1'b0);
      idle(3);

      // halting instance: failure, draining tuple, then an ignored tuple
      put(1, 4'd3, 4'd12, 1'b1, 4'd15, 1'b0);
      put(1, 4'd10, 4'd5, 1'b0, 4'd15, 1'b0);
      put(1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
      put(1, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
      idle(2);
      clr[1] = 1'b1;
      cyc();
      idle(2);

      // clear coinciding with a pending compare and a new tuple
      put(1, 4'd4, 4'd4, 1'b0, 4'd8, 1'b0);
      clr[1] = 1'b1;
      put(1, 4'd5, 4'd5, 1'b0, 4'd10, 1'b0);
      idle(3);

      // saturation of the 2-bit pass counter
      for (int k = 0; k < 5; k++) put(1, 4'(k), 4'd7, 1'b1, 4'(k + 8), 1'b0);
      idle(3);

      // randomized traffic with occasional faults and clears
      for (int k = 0; k < 400; k++) begin
         a   = 4'($urandom_range(0, 15));
         b   = 4'($urandom_range(0, 15));
         cin = 1'($urandom_range(0, 1));
         t   = 5'(a + b + cin);
         if ($urandom_range(0, 3) == 0) t = t ^ 5'($urandom_range(1, 31));
         {cout, sum} = t;
         vld[0] = 1'($urandom_range(0, 1));
         vld[1] = 1'($urandom_range(0, 1));
         clr[0] = ($urandom_range(0, 29) == 0);
         clr[1] = ($urandom_range(0, 9) == 0);
         cyc();
      end
      idle(3);

      // asynchronous reset with a tuple in flight
      put(0, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0);
      put(1, 4'd1, 4'd2, 1'b0, 4'd4, 1'b0);
      rst_n = 1'b0;
      vld[0] = 1'b0; vld[1] = 1'b0;
      #1;
      check("async_reset_outputs",
            {10'd0, cv0, cp0, ef0, pc0, fc0, ea0, eb0, es0, eci0, eco0,
             cv1, cp1, ef1, pc1, fc1, eci1, eco1},
            64'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
